riscv_multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the RISC-V datapath. It issues operation codes to the ALU (ALUctl/A/B/ALUout/zero interface) and consumes the ALU zero flag for branches.
- It sequences fetch, decode, execute, memory and writeback.
- It generates all datapath mux selects and write enables, and counts retired instructions.
- Supported instructions: R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, lw, sw, beq/bne, jal.

---
 rtl/riscv_multicycle_ctrl_pkg.sv | 37 +++
 rtl/riscv_multicycle_ctrl_if.sv | 39 +++
 rtl/riscv_multicycle_ctrl_alu_dec.sv | 27 ++
 rtl/riscv_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
// Contents: FSM state encoding, ALU operation codes, opcode/funct3 values,
// and datapath mux select encodings. No ports.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    FAULT  = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2,
                         ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_NOR = 4'd12;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011, OP_ITYPE = 7'b0010011,
                         OP_LOAD   = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BRANCH = 7'b1100011, OP_JAL   = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLT = 3'b010, F3_OR  = 3'b110,
                         F3_AND = 3'b111, F3_WORD = 3'b010,
                         F3_BEQ = 3'b000, F3_BNE = 3'b001;

  localparam logic [1:0] SRC_A_PC = 2'd0, SRC_A_OLDPC = 2'd1, SRC_A_RS1 = 2'd2;
  localparam logic [1:0] SRC_B_RS2 = 2'd0, SRC_B_FOUR = 2'd1, SRC_B_IMM = 2'd2;
  localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2;
  localparam logic       PC_SRC_ALU = 1'b0, PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master: controller side (consumes instruction fields, zero, mem_ready;
//         drives ALU control, mux selects, enables, fault, retired, state).
// slave:  datapath side (mirror directions).
interface riscv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic [3:0]       alu_ctl;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             fault;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output alu_ctl, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, wb_sel, fault, retired, state
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  alu_ctl, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, wb_sel, fault, retired, state
  );
endinterface

// File: rtl/riscv_multicycle_ctrl_alu_dec.sv
// ALU operation decoder shared by the R-type and I-type execute states.
// Ports: funct3, funct7b5 (instruction bits), use_f7 (1 for R-type so that
// funct7b5 selects SUB), alu_ctl (operation), illegal (unsupported funct3).
module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       use_f7,
  output logic [3:0] alu_ctl,
  output logic       illegal
);

  // Illegal encodings report ADD on alu_ctl; the FSM faults on them anyway.
  always_comb begin
    alu_ctl = ALU_ADD;
    illegal = 1'b0;
    case (funct3)
      F3_ADD:  alu_ctl = (use_f7 && funct7b5) ? ALU_SUB : ALU_ADD;
      F3_AND:  alu_ctl = ALU_AND;
      F3_OR:   alu_ctl = ALU_OR;
      F3_SLT:  alu_ctl = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback, drives ALU op and datapath selects, counts retired instructions.
// Ports: clk, reset (sync, active-high), bus (master modport: opcode,
// funct3, funct7b5, zero, mem_ready in; alu_ctl, alu_src_a/b, iord,
// mem_read/write, ir_write, pc_write, pc_src, reg_write, wb_sel, fault,
// retired, state out).
module riscv_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_multicycle_ctrl_if.master bus
);
  import riscv_ctrl_pkg::*;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic               fault_q;
  logic [CNT_W-1:0]   retired_q;
  logic [3:0]         dec_alu;
  logic               dec_illegal;
  logic               retire;
  logic               mem_wait_state;
  logic               timeout;

  riscv_alu_dec u_alu_dec (
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .use_f7   (state_q == EXEC_R),
    .alu_ctl  (dec_alu),
    .illegal  (dec_illegal)
  );

  // wait_q holds the count of earlier stalled cycles, so the fault fires on
  // the MEM_TIMEOUT-th consecutive mem_ready=0 cycle.
  assign mem_wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout = (MEM_TIMEOUT > 0) && mem_wait_state && !bus.mem_ready &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      FETCH:  if (timeout) state_d = FAULT; else if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:          state_d = EXEC_R;
          OP_ITYPE:          state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = FAULT;
        endcase
      end
      EXEC_R, EXEC_I: state_d = dec_illegal ? FAULT : ALUWB;
      ALUWB, MEMWB, JAL: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEMADR: begin
        if (bus.funct3 != F3_WORD)        state_d = FAULT;
        else if (bus.opcode == OP_LOAD)   state_d = MEMRD;
        else                              state_d = MEMWR;
      end
      MEMRD:  if (timeout) state_d = FAULT; else if (bus.mem_ready) state_d = MEMWB;
      MEMWR: begin
        if (timeout) state_d = FAULT;
        else if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        if (bus.funct3 == F3_BEQ || bus.funct3 == F3_BNE) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = FAULT;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | (state_d == FAULT);
      if (mem_wait_state && !bus.mem_ready && state_d == state_q) wait_q <= wait_q + 1'b1;
      else                                                        wait_q <= '0;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    bus.alu_ctl   = '0;
    bus.alu_src_a = '0;
    bus.alu_src_b = '0;
    bus.iord      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.reg_write = 1'b0;
    bus.wb_sel    = '0;
    unique case (state_q)
      FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.alu_src_a = SRC_A_PC;
          bus.alu_src_b = SRC_B_FOUR;
          bus.alu_ctl   = ALU_ADD;
          bus.pc_write  = 1'b1;
          bus.pc_src    = PC_SRC_ALU;
        end
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_ctl   = ALU_ADD;
      end
      EXEC_R: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_ctl   = dec_alu;
      end
      EXEC_I: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_ctl   = dec_alu;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_ALUOUT;
      end
      MEMADR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_ctl   = ALU_ADD;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEMWB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_MEM;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_ctl   = ALU_SUB;
        bus.pc_src    = PC_SRC_ALUOUT;
        bus.pc_write  = (bus.funct3 == F3_BEQ) ? bus.zero :
                        (bus.funct3 == F3_BNE) ? ~bus.zero : 1'b0;
      end
      JAL: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_PC;
        bus.pc_write  = 1'b1;
        bus.pc_src    = PC_SRC_ALUOUT;
      end
      default: ;
    endcase
  end

  assign bus.fault   = fault_q;
  assign bus.retired = retired_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed scenarios plus
// randomized instruction streams against an instruction-level reference.
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011,
                         SW_OP = 7'b0100011, BR_OP = 7'b1100011, J_OP = 7'b1101111;
  // funct3 -> ALU op for R/I arithmetic; unsupported entries read as ADD.
  localparam logic [3:0] ALU_TAB [8] = '{4'd2, 4'd2, 4'd7, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
  localparam logic [7:0] F3_OK = 8'b1100_0101;
  localparam logic [2:0] F3_LEGAL [4] = '{3'd0, 3'd7, 3'd6, 3'd2};

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       iord, mrd, mwr, irw, pcw, pcs, rw;
    logic [1:0] wb;
    logic       flt;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   model_ret = 0;

  riscv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state;      o.alu = bus.alu_ctl;   o.sa = bus.alu_src_a;
    o.sb = bus.alu_src_b;  o.iord = bus.iord;     o.mrd = bus.mem_read;
    o.mwr = bus.mem_write; o.irw = bus.ir_write;  o.pcw = bus.pc_write;
    o.pcs = bus.pc_src;    o.rw = bus.reg_write;  o.wb = bus.wb_sel;
    o.flt = bus.fault;
    return o;
  endfunction

  function automatic obs_t exp_outs(input state_t s, input logic mr, input logic [2:0] f3,
                                    input logic f7, input logic z);
    obs_t e = '0;
    e.st = s;
    case (s)
      FETCH:  begin
        e.mrd = 1;
        if (mr) begin e.irw = 1; e.sb = 2'd1; e.alu = 4'd2; e.pcw = 1; end
      end
      DECODE: begin e.sa = 2'd1; e.sb = 2'd2; e.alu = 4'd2; end
      EXEC_R: begin e.sa = 2'd2; e.alu = (f3 == 3'd0 && f7) ? 4'd6 : ALU_TAB[f3]; end
      EXEC_I: begin e.sa = 2'd2; e.sb = 2'd2; e.alu = ALU_TAB[f3]; end
      ALUWB:  e.rw = 1;
      MEMADR: begin e.sa = 2'd2; e.sb = 2'd2; e.alu = 4'd2; end
      MEMRD:  begin e.mrd = 1; e.iord = 1; end
      MEMWB:  begin e.rw = 1; e.wb = 2'd1; end
      MEMWR:  begin e.mwr = 1; e.iord = 1; end
      BRANCH: begin
        e.sa = 2'd2; e.alu = 4'd6; e.pcs = 1;
        e.pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
      end
      JAL:    begin e.rw = 1; e.wb = 2'd2; e.pcw = 1; e.pcs = 1; end
      FAULT:  e.flt = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic cycle(input state_t s, input logic mr, input string tag);
    obs_t e, o;
    bus.mem_ready = mr;
    e = exp_outs(s, mr, bus.funct3, bus.funct7b5, bus.zero);
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s in %s: got %h need %h", tag, s.name(), o, e);
    end
    @(posedge clk); #1;
  endtask

  // w stalled cycles then a ready cycle; TMO or more stalls means timeout.
  task automatic mem_phase(input state_t s, input int w, input string tag, output bit to);
    for (int i = 0; i < w && i < TMO; i++) cycle(s, 1'b0, tag);
    to = (w >= TMO);
    if (!to) cycle(s, 1'b1, tag);
  endtask

  task automatic check_retired(input string tag);
    checks++;
    if (bus.retired !== CNT_W'(model_ret)) begin
      errors++;
      $display("FAIL %s retired: got %0d need %0d", tag, bus.retired, CNT_W'(model_ret));
    end
  endtask

  task automatic do_reset(input string tag);
    obs_t e, o;
    reset = 1'b1;
    bus.mem_ready = rb();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    model_ret = 0;
    #1;
    e = exp_outs(FETCH, 1'b0, bus.funct3, bus.funct7b5, bus.zero);
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s reset state: got %h need %h", tag, o, e);
    end
    check_retired(tag);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm, input string tag);
    bit to, flt;
    flt = 0;
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    mem_phase(FETCH, wf, tag, to);
    if (to) flt = 1;
    else begin
      cycle(DECODE, rb(), tag);
      if (op == R_OP || op == I_OP) begin
        cycle((op == R_OP) ? EXEC_R : EXEC_I, rb(), tag);
        if (F3_OK[f3]) begin cycle(ALUWB, rb(), tag); model_ret++; end
        else flt = 1;
      end else if (op == LW_OP || op == SW_OP) begin
        cycle(MEMADR, rb(), tag);
        if (f3 != 3'd2) flt = 1;
        else if (op == LW_OP) begin
          mem_phase(MEMRD, wm, tag, to);
          if (to) flt = 1;
          else begin cycle(MEMWB, rb(), tag); model_ret++; end
        end else begin
          mem_phase(MEMWR, wm, tag, to);
          if (to) flt = 1; else model_ret++;
        end
      end else if (op == BR_OP) begin
        cycle(BRANCH, rb(), tag);
        if (f3 <= 3'd1) model_ret++; else flt = 1;
      end else if (op == J_OP) begin
        cycle(JAL, rb(), tag);
        model_ret++;
      end else flt = 1;
    end
    if (flt) begin
      for (int i = 0; i < 3; i++) cycle(FAULT, rb(), tag);
      do_reset(tag);
    end else check_retired(tag);
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_alu_ops();
    run_instr(R_OP, 3'd0, 1'b0, 1'b0, 0, 0, "add");
    run_instr(R_OP, 3'd0, 1'b1, 1'b0, 0, 0, "sub");
    run_instr(R_OP, 3'd7, 1'b0, 1'b1, 1, 0, "and");
    run_instr(R_OP, 3'd6, 1'b0, 1'b0, 0, 0, "or");
    run_instr(R_OP, 3'd2, 1'b0, 1'b0, 2, 0, "slt");
    run_instr(I_OP, 3'd0, 1'b1, 1'b0, 0, 0, "addi_f7");
    run_instr(I_OP, 3'd2, 1'b0, 1'b0, 0, 0, "slti");
  endtask

  task automatic test_branch_jal();
    run_instr(BR_OP, 3'd0, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(BR_OP, 3'd0, 1'b0, 1'b0, 0, 0, "beq_not");
    run_instr(BR_OP, 3'd1, 1'b0, 1'b0, 0, 0, "bne_taken");
    run_instr(BR_OP, 3'd1, 1'b0, 1'b1, 0, 0, "bne_not");
    run_instr(J_OP,  3'd5, 1'b0, 1'b0, 0, 0, "jal");
  endtask

  task automatic test_mem();
    run_instr(LW_OP, 3'd2, 1'b0, 1'b0, 0, 3, "lw_wait3");
    run_instr(SW_OP, 3'd2, 1'b0, 1'b0, 0, 0, "sw");
    run_instr(SW_OP, 3'd2, 1'b0, 1'b0, 2, 3, "sw_wait");
  endtask

  task automatic test_faults();
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, "bad_opcode");
    run_instr(R_OP, 3'd3, 1'b0, 1'b0, 0, 0, "bad_r_f3");
    run_instr(LW_OP, 3'd0, 1'b0, 1'b0, 0, 0, "bad_lw_f3");
    run_instr(BR_OP, 3'd4, 1'b0, 1'b1, 0, 0, "bad_br_f3");
  endtask

  task automatic test_timeout();
    run_instr(I_OP, 3'd0, 1'b0, 1'b0, TMO, 0, "tmo_fetch");
    run_instr(LW_OP, 3'd2, 1'b0, 1'b0, 0, TMO, "tmo_memrd");
    run_instr(SW_OP, 3'd2, 1'b0, 1'b0, TMO - 1, TMO, "tmo_memwr");
  endtask

  task automatic test_wrap();
    do_reset("wrap");
    for (int i = 0; i < 17; i++)
      run_instr(I_OP, F3_LEGAL[$urandom_range(0, 3)], rb(), rb(), $urandom_range(0, 2), 0, "addi_wrap");
  endtask

  task automatic test_mid_reset();
    run_instr(I_OP, 3'd0, 1'b0, 1'b0, 0, 0, "pre_reset");
    bus.opcode = I_OP; bus.funct3 = 3'd0;
    cycle(FETCH, 1'b1, "mid_reset");
    cycle(DECODE, rb(), "mid_reset");
    reset = 1'b1;
    cycle(EXEC_I, rb(), "mid_reset");
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    model_ret = 0;
    #1;
    checks++;
    if (sample() !== exp_outs(FETCH, 1'b0, bus.funct3, bus.funct7b5, bus.zero)) begin
      errors++;
      $display("FAIL mid_reset after: got %h state=%0d reg_write=%b", sample(), bus.state, bus.reg_write);
    end
    check_retired("mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [2:0] f3;
    int k, wf, wm;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      f3 = 3'($urandom_range(0, 7));
      if (k < 5)       begin op = R_OP;  if ($urandom_range(0, 9) != 0) f3 = F3_LEGAL[$urandom_range(0, 3)]; end
      else if (k < 9)  begin op = I_OP;  if ($urandom_range(0, 9) != 0) f3 = F3_LEGAL[$urandom_range(0, 3)]; end
      else if (k < 12) begin op = LW_OP; if ($urandom_range(0, 9) != 0) f3 = 3'd2; end
      else if (k < 14) begin op = SW_OP; if ($urandom_range(0, 9) != 0) f3 = 3'd2; end
      else if (k < 17) begin op = BR_OP; if ($urandom_range(0, 9) != 0) f3 = 3'($urandom_range(0, 1)); end
      else if (k < 19) op = J_OP;
      else             op = 7'($urandom_range(0, 127));
      wf = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      wm = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(op, f3, rb(), rb(), wf, wm, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu_ops();
    test_branch_jal();
    test_mem();
    test_faults();
    test_timeout();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
